// File: rtl/byte_pack32.sv
// Packs a stream of bytes into 32-bit words, first byte in the low lane, behind a one-word output register.
// The optional partial-word flush input is present only when BYTE_PACK32_FLUSH_EN is defined.
module byte_pack32 #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_count
`ifdef BYTE_PACK32_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  logic [23:0] asm_q;
  logic [23:0] asm_ins;
  logic [1:0]  cnt;
  logic        slot_free;
  logic        accept;
  logic        last;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (cnt != 2'd3) || slot_free;
  assign accept    = in_valid && in_ready;
  assign last      = accept && (cnt == 2'd3);

  // Assembly register with the incoming byte already placed in lane cnt.
  always_comb begin
    asm_ins = asm_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (accept && (32'(cnt) == i)) asm_ins[8*i +: 8] = in_data;
    end
  end

`ifdef BYTE_PACK32_FLUSH_EN
  logic [2:0]  eff;
  logic        do_flush;
  logic [31:0] flush_word;

  assign eff = {1'b0, cnt} + {2'b00, accept};
  // A count of four is handled as an ordinary full word, so flush only covers 1..3 lanes.
  assign do_flush = flush && (eff != 3'd0) && slot_free && !last;

  always_comb begin
    flush_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < 32'(eff)) flush_word[8*i +: 8] = asm_ins[8*(i%3) +: 8];
      else              flush_word[8*i +: 8] = PAD_BYTE;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      asm_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (last) begin
        out_data  <= {in_data, asm_q};
        out_count <= 3'd4;
        out_valid <= 1'b1;
        cnt       <= '0;
        asm_q     <= '0;
      end
`ifdef BYTE_PACK32_FLUSH_EN
      else if (do_flush) begin
        out_data  <= flush_word;
        out_count <= eff;
        out_valid <= 1'b1;
        cnt       <= '0;
        asm_q     <= '0;
      end
`endif
      else if (accept) begin
        asm_q <= asm_ins;
        cnt   <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_byte_pack32.sv
// Randomised and directed bench for byte_pack32 against a queue-based packing model.
// Define BYTE_PACK32_FLUSH_EN for both files to exercise the flush feature.
module tb_byte_pack32;

  localparam logic [7:0] PAD = 8'hEE;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
`ifdef BYTE_PACK32_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: bytes waiting to form a word, plus the single output slot.
  logic [7:0]  part[$];
  logic        mv = 1'b0;
  logic [31:0] md = '0;
  logic [2:0]  mc = '0;
  logic        acc;

  always #5 clk = ~clk;

  byte_pack32 #(.PAD_BYTE(PAD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef BYTE_PACK32_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) begin
      w = w | ({24'h0, (i < part.size()) ? part[i] : PAD} << (8 * i));
    end
    return w;
  endfunction

  // One clock: drive at negedge, check outputs, then advance the model past the posedge.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic ordy, input logic fl, output logic a);
    logic exp_rdy;
    logic free;
    @(negedge clk);
    resetn = r; in_valid = v; in_data = d; out_ready = ordy;
`ifdef BYTE_PACK32_FLUSH_EN
    flush = fl;
`endif
    #1;
    exp_rdy = (part.size() != 3) || !mv || ordy;
    free    = !mv || ordy;
    check("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    check("out_valid", {31'h0, out_valid}, {31'h0, mv});
    if (mv) begin
      check("out_data", out_data, md);
      check("out_count", {29'h0, out_count}, {29'h0, mc});
    end
    a = r && v && exp_rdy;
    @(posedge clk);
    if (!r) begin
      part.delete();
      mv = 1'b0; md = '0; mc = '0;
    end else begin
      if (mv && ordy) mv = 1'b0;
      if (a) part.push_back(d);
      if (part.size() == 4) begin
        md = pack_word(); mc = 3'd4; mv = 1'b1;
        part.delete();
      end
`ifdef BYTE_PACK32_FLUSH_EN
      else if (fl && part.size() > 0 && free) begin
        md = pack_word(); mc = 3'(part.size()); mv = 1'b1;
        part.delete();
      end
`else
      else if (fl && free) begin
        // flush has no effect in this build
      end
`endif
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, 1'b1, b, 1'b1, 1'b0, acc);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic [2:0] c);
    #2;
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, {29'h0, out_count}, {29'h0, c});
  endtask

  task automatic expect_idle(input string tag);
    #2;
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    logic [7:0] idx;

    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b0, 1'b1, 8'h5C, 1'b0, 1'b0, acc);
    #2;
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_count", {29'h0, out_count}, 32'h0);

    // Four bytes, one word.
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    expect_word("w4", 32'h44332211, 3'd4);

    // Eight bytes back to back.
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      if (i == 4) expect_word("bb1", 32'h04030201, 3'd4);
    end
    expect_word("bb2", 32'h08070605, 3'd4);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Stalled output: first word held, byte 8 refused at cnt=3.
    idx = 8'd1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, idx, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    expect_word("hold", 32'h04030201, 3'd4);
    check("hold_in_ready", {31'h0, in_ready}, 32'h0);
    step(1'b1, 1'b1, idx, 1'b1, 1'b0, acc);
    expect_word("rel", 32'h08070605, 3'd4);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Reset discards a partial word.
    send(8'hAA); send(8'hBB);
    step(1'b0, 1'b1, 8'hCC, 1'b1, 1'b0, acc);
    expect_idle("mid_rst");
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    expect_word("post_rst", 32'h04030201, 3'd4);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

`ifdef BYTE_PACK32_FLUSH_EN
    send(8'h5A); send(8'h6B);
    step(1'b1, 1'b1, 8'h7C, 1'b1, 1'b1, acc);
    expect_word("flush3", 32'hEE7C6B5A, 3'd3);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    expect_idle("flush0");
    send(8'h91); send(8'h92); send(8'h93);
    step(1'b1, 1'b1, 8'h94, 1'b1, 1'b1, acc);
    expect_word("flush4", 32'h94939291, 3'd4);
`endif

    for (int n = 0; n < 800; n++) begin
      step(($urandom % 60) != 0, ($urandom % 4) != 0, 8'($urandom),
           ($urandom % 3) != 0, ($urandom % 6) == 0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_pack32.md
BYTE_PACK32 -- requirements
Module: byte_pack32

Interface
REQ-001 The block SHALL have parameter: PAD_BYTE, 8'h00, fill value for unused byte lanes of a flushed partial word.
REQ-002 The block SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The block SHALL have port: resetn  input  1  synchronous active-low reset.
REQ-004 The block SHALL have port: in_valid  input  1  upstream byte present (driven from the shift8 tap-select output stage).
REQ-005 The block SHALL have port: in_data  input  8  upstream byte.
REQ-006 The block SHALL have port: in_ready  output  1  byte accepted on an edge where in_valid && in_ready.
REQ-007 The block SHALL have port: out_valid  output  1  out_data/out_count hold a word.
REQ-008 The block SHALL have port: out_ready  input  1  downstream accepts on an edge where out_valid && out_ready.
REQ-009 The block SHALL have port: out_data  output  32  packed word, first accepted byte in [7:0], fourth in [31:24].
REQ-010 The block SHALL have port: out_count  output  3  number of valid byte lanes in out_data, 1..4.
REQ-011 The block SHALL have port, only when BYTE_PACK32_FLUSH_EN is defined: flush  input  1  request emission of a partial word.

Function
REQ-012 The block SHALL hold an assembly register (24 bits) and a byte counter cnt in the range 0..3, plus one output word register.
REQ-013 The block SHALL store an accepted byte in lane cnt and increment cnt, with cnt wrapping 3->0 when the fourth byte is accepted.
REQ-014 The block SHALL load the output register with {in_data, assembly[23:0]}, assert out_count=4 and out_valid=1 on the same edge the fourth byte is accepted (1-cycle latency from last byte to out_valid).
REQ-015 The block SHALL drive in_ready = (cnt != 3) || !out_valid || out_ready (combinational from out_ready permitted).
REQ-016 The block SHALL keep out_data, out_count and out_valid stable while out_valid && !out_ready.
REQ-017 The block SHALL clear out_valid on a handshake edge unless a new word is loaded on that same edge, in which case out_valid stays 1 with the new word (back-to-back, no bubble).
REQ-018 The block SHALL sustain one accepted byte per cycle when out_ready is held 1.
REQ-019 The block SHALL ignore in_data when in_valid=0 or in_ready=0, with no state change.

Reset
REQ-020 The block SHALL, on an edge with resetn=0, set cnt=0, assembly=0, out_valid=0, out_data=0 and out_count=0, overriding all other inputs.
REQ-021 The block SHALL discard any partially assembled or undelivered word on reset mid-operation, and SHALL drive in_ready=1 on the first cycle after reset.

Configuration
REQ-022 With BYTE_PACK32_FLUSH_EN defined, the block SHALL treat an edge where flush=1, effective count > 0 and the output slot is free or draining as a flush: emit lanes 0..count-1, fill remaining lanes with PAD_BYTE, set out_count=count, and set cnt=0.
REQ-023 With BYTE_PACK32_FLUSH_EN defined, the block SHALL compute effective count as cnt plus 1 if a byte is accepted on the same edge, so that a simultaneously accepted byte is included in the flushed word; a 4-byte result SHALL be a normal full word.
REQ-024 With BYTE_PACK32_FLUSH_EN defined, the block SHALL ignore flush when effective count = 0, and SHALL hold flush pending, with no state change, while the output slot is blocked.
REQ-025 Without BYTE_PACK32_FLUSH_EN, the block SHALL have no flush port and no flush logic, and out_count SHALL read 4 whenever out_valid=1.

Verification
REQ-026 The bench SHALL cover: bytes 11,22,33,44 on consecutive cycles with out_ready=1 -> out_valid next cycle, out_data=32'h44332211, out_count=4.
REQ-027 The bench SHALL cover: 8 bytes 01..08 back-to-back with out_ready=1 -> words 32'h04030201 then 32'h08070605, in_ready constantly 1.
REQ-028 The bench SHALL cover: out_ready=0 with 7 bytes offered -> first word held stable, in_ready=0 at cnt=3; release out_ready -> 32'h04030201 delivered, then 05..08 complete the next word.
REQ-029 The bench SHALL cover: resetn=0 after 2 bytes AA,BB -> out_valid=0, cnt=0; then 01,02,03,04 -> out_data=32'h04030201.
REQ-030 The bench SHALL cover, with FLUSH_EN and PAD_BYTE=8'hEE: bytes 5A,6B then flush together with byte 7C -> out_data=32'hEE7C6B5A, out_count=3.
REQ-031 The bench SHALL cover, with FLUSH_EN: flush at cnt=0 -> no out_valid.
